// File: rtl/cpu_pkg.sv
// Shared pipeline constants, the per-stage destination record and the hazard FSM state type.
package cpu_pkg;

  localparam logic [3:0] OP_LD  = 4'b1110;
  localparam logic [3:0] OP_INC = 4'b0101;
  localparam int unsigned REG_W = 6;

  typedef struct packed {
    logic             valid;
    logic [REG_W-1:0] rd;
    logic             regwrt;
    logic             is_load;
  } stage_rec_t;

  typedef enum logic {
    StRun,
    StStall
  } hsu_state_e;

endpackage

// File: rtl/stage_tag_pipe.sv
// EX/MEM/WB destination-tag shift register; a bubble loads an invalid record into EX.
module stage_tag_pipe
  import cpu_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             bubble,
  input  logic             id_valid,
  input  logic [3:0]       id_op,
  input  logic [REG_W-1:0] id_rd,
  input  logic             id_regwrt,
  output stage_rec_t       ex,
  output logic [REG_W-1:0] ex_rd,
  output logic [REG_W-1:0] mem_rd,
  output logic             mem_regwrt,
  output logic [REG_W-1:0] wb_rd,
  output logic             wb_regwrt
);

  stage_rec_t       ex_q, ex_d, mem_q;
  logic             wb_valid_q, wb_regwrt_q;
  logic [REG_W-1:0] wb_rd_q;

  always_comb begin
    ex_d = '0;
    if (!bubble && id_valid) begin
      ex_d.valid   = 1'b1;
      ex_d.rd      = id_rd;
      ex_d.regwrt  = id_regwrt;
      ex_d.is_load = (id_op == OP_LD);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_q        <= '0;
      mem_q       <= '0;
      wb_valid_q  <= 1'b0;
      wb_rd_q     <= '0;
      wb_regwrt_q <= 1'b0;
    end else begin
      ex_q        <= ex_d;
      mem_q       <= ex_q;
      wb_valid_q  <= mem_q.valid;
      wb_rd_q     <= mem_q.rd;
      wb_regwrt_q <= mem_q.regwrt;
    end
  end

  // Tags read as 0 for empty stages so the forwarding unit never matches a bubble.
  always_comb begin
    ex         = ex_q;
    ex_rd      = ex_q.valid ? ex_q.rd : '0;
    mem_rd     = mem_q.valid ? mem_q.rd : '0;
    mem_regwrt = mem_q.valid & mem_q.regwrt;
    wb_rd      = wb_valid_q ? wb_rd_q : '0;
    wb_regwrt  = wb_valid_q & wb_regwrt_q;
  end

endmodule

// File: rtl/hazard_stall_unit.sv
// Load-use hazard detector: stalls IF/ID for LD_LAT cycles and publishes in-flight tags.
module hazard_stall_unit
  import cpu_pkg::*;
#(
  parameter int unsigned LD_LAT = 1,
  parameter int unsigned CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [3:0]       id_op,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic [REG_W-1:0] id_rd,
  input  logic             id_regwrt,
  input  logic             id_pc_to_alu,
  input  logic             id_const,
  input  logic             flush,
  output logic             stall,
  output logic             bubble,
  output logic [REG_W-1:0] ex_rd,
  output logic [REG_W-1:0] mem_rd,
  output logic [REG_W-1:0] wb_rd,
  output logic             mem_regwrt,
  output logic             wb_regwrt,
  output logic [CNT_W-1:0] stall_cnt
);

  hsu_state_e       state_q;
  logic [1:0]       cnt_q;
  logic [CNT_W-1:0] stall_cnt_q;
  stage_rec_t       ex;
  logic             haz;
  logic             src_match;

  stage_tag_pipe u_stage_tag_pipe (
    .clk        (clk),
    .rst        (rst),
    .bubble     (bubble),
    .id_valid   (id_valid),
    .id_op      (id_op),
    .id_rd      (id_rd),
    .id_regwrt  (id_regwrt),
    .ex         (ex),
    .ex_rd      (ex_rd),
    .mem_rd     (mem_rd),
    .mem_regwrt (mem_regwrt),
    .wb_rd      (wb_rd),
    .wb_regwrt  (wb_regwrt)
  );

  always_comb begin
    src_match = (!id_pc_to_alu && (id_rs == ex.rd)) || (!id_const && (id_rt == ex.rd));
    haz = (state_q == StRun) && id_valid && ex.valid && ex.is_load && ex.regwrt &&
          (ex.rd != '0) && (id_op != OP_INC) && src_match;
    stall  = !flush && ((state_q == StStall) || haz);
    bubble = stall || flush;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StRun;
      cnt_q   <= '0;
    end else if (flush) begin
      state_q <= StRun;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        StRun: begin
          if (haz && (LD_LAT > 1)) begin
            cnt_q   <= 2'(LD_LAT - 1);
            state_q <= StStall;
          end
        end
        StStall: begin
          cnt_q <= cnt_q - 2'd1;
          if (cnt_q == 2'd1) state_q <= StRun;
        end
        default: state_q <= StRun;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_q <= '0;
    end else if (stall && (stall_cnt_q != '1)) begin
      stall_cnt_q <= stall_cnt_q + 1'b1;
    end
  end

  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Directed bench for hazard_stall_unit: LD_LAT=1 and LD_LAT=3 instances share one ID stream.
module tb_hazard_stall_unit;
  import cpu_pkg::*;

  logic             clk = 1'b0;
  logic             rst;
  logic             id_valid;
  logic [3:0]       id_op;
  logic [REG_W-1:0] id_rs, id_rt, id_rd;
  logic             id_regwrt, id_pc_to_alu, id_const, flush;

  logic             stall1, bubble1, mem_regwrt1, wb_regwrt1;
  logic [REG_W-1:0] ex_rd1, mem_rd1, wb_rd1;
  logic [15:0]      stall_cnt1;
  logic             stall3, bubble3, mem_regwrt3, wb_regwrt3;
  logic [REG_W-1:0] ex_rd3, mem_rd3, wb_rd3;
  logic [15:0]      stall_cnt3;

  int n_checks = 0;
  int n_errors = 0;

  localparam logic [3:0] OP_ADD = 4'b0000;

  always #5 clk = ~clk;

  hazard_stall_unit #(.LD_LAT(1), .CNT_W(16)) u_dut1 (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_op(id_op), .id_rs(id_rs), .id_rt(id_rt),
    .id_rd(id_rd), .id_regwrt(id_regwrt), .id_pc_to_alu(id_pc_to_alu), .id_const(id_const),
    .flush(flush), .stall(stall1), .bubble(bubble1), .ex_rd(ex_rd1), .mem_rd(mem_rd1),
    .wb_rd(wb_rd1), .mem_regwrt(mem_regwrt1), .wb_regwrt(wb_regwrt1), .stall_cnt(stall_cnt1)
  );

  hazard_stall_unit #(.LD_LAT(3), .CNT_W(16)) u_dut3 (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_op(id_op), .id_rs(id_rs), .id_rt(id_rt),
    .id_rd(id_rd), .id_regwrt(id_regwrt), .id_pc_to_alu(id_pc_to_alu), .id_const(id_const),
    .flush(flush), .stall(stall3), .bubble(bubble3), .ex_rd(ex_rd3), .mem_rd(mem_rd3),
    .wb_rd(wb_rd3), .mem_regwrt(mem_regwrt3), .wb_regwrt(wb_regwrt3), .stall_cnt(stall_cnt3)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic idle();
    id_valid = 1'b0; id_op = OP_ADD; id_rs = '0; id_rt = '0; id_rd = '0;
    id_regwrt = 1'b0; id_pc_to_alu = 1'b0; id_const = 1'b0; flush = 1'b0;
  endtask

  task automatic id_set(input logic [3:0] op, input int rs, input int rt, input int rd,
                        input logic pc, input logic cst);
    id_valid = 1'b1; id_op = op; id_rs = 6'(rs); id_rt = 6'(rt); id_rd = 6'(rd);
    id_regwrt = 1'b1; id_pc_to_alu = pc; id_const = cst; flush = 1'b0;
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are sampled 1 unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic check_zero(input string tag);
    check_eq({tag, " stall1"}, 32'(stall1), 0);
    check_eq({tag, " bubble1"}, 32'(bubble1), 0);
    check_eq({tag, " tags1"}, 32'({ex_rd1, mem_rd1, wb_rd1, mem_regwrt1, wb_regwrt1}), 0);
    check_eq({tag, " cnt1"}, 32'(stall_cnt1), 0);
    check_eq({tag, " stall3"}, 32'(stall3), 0);
    check_eq({tag, " tags3"}, 32'({ex_rd3, mem_rd3, wb_rd3, mem_regwrt3, wb_regwrt3}), 0);
    check_eq({tag, " cnt3"}, 32'(stall_cnt3), 0);
  endtask

  initial begin
    idle();
    rst = 1'b1;
    #3;
    check_zero("reset");
    do_reset();

    // Load-use on rs: LD r5, then ADD r7,r5,r2 held in ID while stalled
    id_set(OP_LD, 0, 0, 5, 1'b0, 1'b0); settle();
    check_eq("lu ld stall1", 32'(stall1), 0);
    check_eq("lu ld stall3", 32'(stall3), 0);
    tick(); id_set(OP_ADD, 5, 2, 7, 1'b0, 1'b0); settle();
    check_eq("lu haz stall1", 32'(stall1), 1);
    check_eq("lu haz bubble1", 32'(bubble1), 1);
    check_eq("lu haz ex_rd1", 32'(ex_rd1), 5);
    check_eq("lu haz stall3", 32'(stall3), 1);
    tick(); settle();
    check_eq("lu c3 stall1", 32'(stall1), 0);
    check_eq("lu c3 ex_rd1", 32'(ex_rd1), 0);
    check_eq("lu c3 mem_rd1", 32'(mem_rd1), 5);
    check_eq("lu c3 cnt1", 32'(stall_cnt1), 1);
    check_eq("lu c3 stall3", 32'(stall3), 1);
    tick(); settle();
    check_eq("lu c4 ex_rd1", 32'(ex_rd1), 7);
    check_eq("lu c4 wb_rd1", 32'(wb_rd1), 5);
    check_eq("lu c4 stall3", 32'(stall3), 1);
    check_eq("lu c4 bubble3", 32'(bubble3), 1);
    tick(); settle();
    check_eq("lu c5 stall3", 32'(stall3), 0);
    check_eq("lu c5 cnt3", 32'(stall_cnt3), 3);
    check_eq("lu c5 ex_rd3", 32'(ex_rd3), 0);
    check_eq("lu c5 cnt1", 32'(stall_cnt1), 1);
    tick(); idle(); settle();
    check_eq("lu c6 ex_rd3", 32'(ex_rd3), 7);
    check_eq("lu c6 stall3", 32'(stall3), 0);

    // Cases that must never stall
    do_reset();
    id_set(OP_LD, 0, 0, 0, 1'b0, 1'b0);
    tick(); id_set(OP_ADD, 0, 0, 7, 1'b0, 1'b0); settle();
    check_eq("ns r0 stall1", 32'(stall1), 0);
    check_eq("ns r0 stall3", 32'(stall3), 0);
    tick(); id_set(OP_LD, 0, 0, 5, 1'b0, 1'b0);
    tick(); id_set(OP_INC, 5, 5, 5, 1'b0, 1'b0); settle();
    check_eq("ns inc stall1", 32'(stall1), 0);
    check_eq("ns inc stall3", 32'(stall3), 0);
    tick(); id_set(OP_LD, 0, 0, 5, 1'b0, 1'b0);
    tick(); id_set(OP_ADD, 2, 5, 7, 1'b0, 1'b1); settle();
    check_eq("ns const stall1", 32'(stall1), 0);
    check_eq("ns const stall3", 32'(stall3), 0);
    tick(); id_set(OP_LD, 0, 0, 5, 1'b0, 1'b0);
    tick(); id_set(OP_ADD, 5, 2, 7, 1'b1, 1'b0); settle();
    check_eq("ns pc stall1", 32'(stall1), 0);
    tick(); idle(); settle();
    check_eq("ns cnt1", 32'(stall_cnt1), 0);
    check_eq("ns cnt3", 32'(stall_cnt3), 0);

    // flush coincident with the hazard
    do_reset();
    id_set(OP_LD, 0, 0, 5, 1'b0, 1'b0);
    tick(); id_set(OP_ADD, 5, 2, 7, 1'b0, 1'b0); flush = 1'b1; settle();
    check_eq("fl haz stall1", 32'(stall1), 0);
    check_eq("fl haz bubble1", 32'(bubble1), 1);
    check_eq("fl haz stall3", 32'(stall3), 0);
    tick(); idle(); settle();
    check_eq("fl post ex_rd1", 32'(ex_rd1), 0);
    check_eq("fl post ex_rd3", 32'(ex_rd3), 0);
    check_eq("fl post stall3", 32'(stall3), 0);
    check_eq("fl post cnt1", 32'(stall_cnt1), 0);
    check_eq("fl post cnt3", 32'(stall_cnt3), 0);

    // flush on the second cycle of a 3-cycle stall
    id_set(OP_LD, 0, 0, 5, 1'b0, 1'b0);
    tick(); id_set(OP_ADD, 5, 2, 7, 1'b0, 1'b0); settle();
    check_eq("fl2 c1 stall3", 32'(stall3), 1);
    tick(); flush = 1'b1; settle();
    check_eq("fl2 c2 stall3", 32'(stall3), 0);
    check_eq("fl2 c2 bubble3", 32'(bubble3), 1);
    tick(); idle(); settle();
    check_eq("fl2 c3 stall3", 32'(stall3), 0);
    check_eq("fl2 c3 ex_rd3", 32'(ex_rd3), 0);
    check_eq("fl2 c3 cnt3", 32'(stall_cnt3), 1);
    check_eq("fl2 c3 cnt1", 32'(stall_cnt1), 1);

    // Back-to-back ALU ops writing r3, r4, r5
    do_reset();
    id_set(OP_ADD, 1, 2, 3, 1'b0, 1'b0);
    tick(); id_set(OP_ADD, 1, 2, 4, 1'b0, 1'b0); settle();
    check_eq("b2b c2 ex_rd", 32'(ex_rd1), 3);
    tick(); id_set(OP_ADD, 1, 2, 5, 1'b0, 1'b0); settle();
    check_eq("b2b c3 ex/mem", 32'({ex_rd1, mem_rd1}), 32'({6'd4, 6'd3}));
    tick(); idle(); settle();
    check_eq("b2b c4 ex/mem/wb", 32'({ex_rd1, mem_rd1, wb_rd1}), 32'({6'd5, 6'd4, 6'd3}));
    check_eq("b2b c4 regwrt", 32'({mem_regwrt1, wb_regwrt1}), 3);
    check_eq("b2b c4 ex_rd3", 32'(ex_rd3), 5);
    tick(); settle();
    check_eq("b2b c5 ex/mem/wb", 32'({ex_rd1, mem_rd1, wb_rd1}), 32'({6'd0, 6'd5, 6'd4}));
    tick(); settle();
    check_eq("b2b c6 wb_rd", 32'(wb_rd1), 5);
    check_eq("b2b cnt1", 32'(stall_cnt1), 0);
    check_eq("b2b cnt3", 32'(stall_cnt3), 0);

    // Asynchronous reset in the middle of a STALL
    tick(); id_set(OP_LD, 0, 0, 5, 1'b0, 1'b0);
    tick(); id_set(OP_ADD, 5, 2, 7, 1'b0, 1'b0);
    tick(); settle();
    check_eq("rs pre stall3", 32'(stall3), 1);
    #1 rst = 1'b1;
    #1;
    check_zero("rs mid");
    check_eq("rs mid bubble3", 32'(bubble3), 0);
    @(negedge clk);
    rst = 1'b0;
    tick(); idle(); id_set(OP_LD, 0, 0, 5, 1'b0, 1'b0);
    tick(); id_set(OP_ADD, 5, 2, 7, 1'b0, 1'b0); settle();
    check_eq("rs post stall1", 32'(stall1), 1);
    check_eq("rs post stall3", 32'(stall3), 1);
    tick(); settle();
    check_eq("rs post c2 stall1", 32'(stall1), 0);
    check_eq("rs post c2 ex_rd1", 32'(ex_rd1), 0);
    check_eq("rs post c2 cnt1", 32'(stall_cnt1), 1);
    tick(); idle();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/hazard_stall_unit.md
# hazard_stall_unit

Producer side of the EX-stage operand-forwarding path. Tracks destination tags of instructions in flight through EX, MEM and WB, and publishes them to the forwarding unit. Detects load-use hazards that forwarding cannot resolve, and stalls IF/ID while injecting bubbles into ID/EX. Sits beside the ID/EX pipeline register in the CPU pipeline.

## Interface
Parameters:
- LD_LAT, 1: stall cycles per load-use hazard; legal range 1..3.
- CNT_W, 16: width of the stall performance counter.

Ports:
- clk  in  1  pipeline clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- id_valid  in  1  ID stage holds a real instruction.
- id_op  in  4  opcode in ID.
- id_rs, id_rt, id_rd  in  6 each  source and destination registers in ID.
- id_regwrt  in  1  ID instruction writes id_rd.
- id_pc_to_alu  in  1  1 = ALU operand A is the PC, so rs is unused.
- id_const  in  1  1 = ALU operand B is a constant, so rt is unused.
- flush  in  1  taken branch/jump resolved in EX.
- stall  out  1  hold PC and IF/ID (combinational).
- bubble  out  1  ID/EX loads a NOP this cycle (combinational).
- ex_rd, mem_rd, wb_rd  out  6 each  destination tag per stage; 0 when the stage is invalid.
- mem_regwrt, wb_regwrt  out  1 each  write-enable per stage; 0 when the stage is invalid.
- stall_cnt  out  CNT_W  saturating count of stall cycles.

## Operation
- Per-stage record for EX, MEM and WB: valid, rd, regwrt, is_load. is_load = (op == OP_LD).
- Hazard term `haz`, evaluated only in state RUN. haz is 1 when all of these hold:
  - id_valid, ex.valid, ex.is_load and ex.regwrt are all 1;
  - ex.rd != 0;
  - id_op != OP_INC;
  - (!id_pc_to_alu && id_rs == ex.rd) || (!id_const && id_rt == ex.rd).
- FSM states: RUN, STALL.
  - RUN: stall = haz. On haz with LD_LAT > 1: cnt <= LD_LAT-1, go to STALL. Otherwise stay in RUN.
  - STALL: stall = 1; cnt <= cnt-1; return to RUN when cnt == 1.
  - Total stall cycles per hazard = LD_LAT.
- bubble = stall || flush.
- Stage advance every cycle:
  - wb <= mem; mem <= ex.
  - ex <= invalid if bubble, else the ID fields qualified by id_valid.
- flush has priority over stall:
  - forces stall = 0;
  - state <= RUN;
  - the ID instruction is not captured into EX.
- stall_cnt increments on every cycle with stall = 1 and saturates at all-ones.
- Reset values:
  - all stage valids 0;
  - all rd/regwrt outputs 0;
  - stall and bubble 0;
  - state RUN, cnt 0, stall_cnt 0.
  - Reset mid-STALL drops the stall immediately, because the reset is asynchronous.

## Timing
- Tag outputs are registered: an instruction in ID at cycle n appears on ex_rd at n+1, mem_rd at n+2 and wb_rd at n+3.
- stall and bubble are combinational from the ID inputs and the registered EX record, within the same cycle.
- Load-use with LD_LAT = 1: exactly one stall cycle. The dependent instruction enters EX two cycles after the load, when the load sits in WB, and is then forwarded from WB.
- A register-0 destination never stalls. OP_INC never stalls.
- Simultaneous haz and flush: flush wins and no stall is counted.

## Structure
- Shared package cpu_pkg holds:
  - OP_LD = 4'b1110 and OP_INC = 4'b0101;
  - REG_W = 6;
  - the stage-record typedef {valid, rd, regwrt, is_load};
  - the FSM state enum.
- The forwarding unit consumes the same constants from cpu_pkg.
- Single sub-module stage_tag_pipe: the three-deep record shift register with bubble insertion. The FSM and counter stay in the top module.

## Test plan
- Load-use on rs: ID holds LD r5 (regwrt=1), next cycle ID holds ADD r7,r5,r2 with pc_to_alu=0, LD_LAT=1 -> stall=1 and bubble=1 for one cycle; ex_rd=0 the following cycle; stall_cnt=1.
- Same sequence with LD_LAT=3 -> stall high for exactly 3 consecutive cycles, FSM passes through STALL, stall_cnt=3.
- Load to r0, or a dependent instruction with op=OP_INC, or a dependent instruction with const=1 on the matching rt -> stall stays 0 throughout.
- flush asserted in the haz cycle and on the second cycle of a LD_LAT=3 stall -> stall drops that cycle, state returns to RUN, ex_rd=0 next cycle.
- Back-to-back ALU ops writing r3, r4, r5 -> ex_rd/mem_rd/wb_rd show 3/4/5 shifting one stage per cycle with regwrt=1; stall never asserts.
- rst pulsed mid-STALL -> all outputs 0 asynchronously; stall_cnt=0; the first post-reset hazard behaves as in the first scenario.
